// File: rtl/mef_vedacao.sv
// ---------------------------------------------------------------------------
// mef_vedacao -- sealing-stage controller, downstream of the main bottling FSM.
//
// Takes the bottle-at-seal-position level (pos_ve), runs the capping actuator
// through a timed lower (DS) / retract (SB) cycle, then holds ve_done until
// the main FSM drops pos_ve. Tracks the cork magazine and raises alarme when
// it is empty so the main FSM can hold the conveyor.
//
// Optional feature macro: VEDACAO_CONTADOR_EN
//   When defined, adds a 16-bit saturating count of completed seals.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          line enable; low aborts to idle
//   pos_ve         bottle in sealing position (level)
//   reabastecer    single-cycle pulse: magazine refilled to ROLHAS_MAX
//   vedador        actuator down command
//   ve_done        sealing complete (level)
//   alarme         cork stock empty, or faulted waiting for refill
//   ocupado        block busy (not idle)
//   rolhas         current cork count
//   total_vedadas  completed-seal count (VEDACAO_CONTADOR_EN only)
// ---------------------------------------------------------------------------
module mef_vedacao #(
    parameter int T_DESCE    = 4,
    parameter int T_SOBE     = 2,
    parameter int ROLHAS_MAX = 15,
    parameter int ROLHAS_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pos_ve,
    input  logic                reabastecer,
    output logic                vedador,
    output logic                ve_done,
    output logic                alarme,
    output logic                ocupado,
    output logic [ROLHAS_W-1:0] rolhas
`ifdef VEDACAO_CONTADOR_EN
    ,
    output logic [15:0]         total_vedadas
`endif
);

    typedef enum logic [2:0] {ID, DS, SB, OK, FA} state_t;

    localparam logic [7:0]          TD_LD = 8'(T_DESCE - 1);
    localparam logic [7:0]          TS_LD = 8'(T_SOBE - 1);
    localparam logic [ROLHAS_W-1:0] RMAX  = ROLHAS_W'(ROLHAS_MAX);

    state_t              state_q, state_d;
    logic [7:0]          timer_q, timer_d;
    logic [ROLHAS_W-1:0] rolhas_q, rolhas_d;
    logic                consume;
    logic                vedador_q, ve_done_q, alarme_q, ocupado_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        consume = 1'b0;
        if (!start) begin
            // Abort wins over everything; a cork already taken is not returned.
            state_d = ID;
            timer_d = '0;
        end else begin
            case (state_q)
                ID: if (pos_ve) begin
                    if (rolhas_q != '0) begin
                        state_d = DS;
                        timer_d = TD_LD;
                        consume = 1'b1;
                    end else begin
                        state_d = FA;
                    end
                end
                DS: if (timer_q == '0) begin
                    state_d = SB;
                    timer_d = TS_LD;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
                SB: if (timer_q == '0) state_d = OK;
                    else timer_d = timer_q - 8'd1;
                // Leaving OK only through ID means a held pos_ve cannot reseal.
                OK: if (!pos_ve) state_d = ID;
                FA: if (reabastecer) state_d = ID;
                default: state_d = ID;
            endcase
        end
        // Refill and consume in the same cycle nets to ROLHAS_MAX-1.
        rolhas_d = (reabastecer ? RMAX : rolhas_q) - {{(ROLHAS_W-1){1'b0}}, consume};
    end

    // Outputs are registered from next state so they match the Moore decode
    // of the state register cycle for cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ID;
            timer_q   <= '0;
            rolhas_q  <= RMAX;
            vedador_q <= 1'b0;
            ve_done_q <= 1'b0;
            alarme_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rolhas_q  <= rolhas_d;
            vedador_q <= (state_d == DS);
            ve_done_q <= (state_d == OK);
            alarme_q  <= (rolhas_d == '0) || (state_d == FA);
            ocupado_q <= (state_d != ID);
        end
    end

    assign vedador = vedador_q;
    assign ve_done = ve_done_q;
    assign alarme  = alarme_q;
    assign ocupado = ocupado_q;
    assign rolhas  = rolhas_q;

`ifdef VEDACAO_CONTADOR_EN
    logic [15:0] tot_q;

    // Counts only real completions (SB->OK); saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tot_q <= '0;
        end else if (state_q == SB && state_d == OK && tot_q != 16'hFFFF) begin
            tot_q <= tot_q + 16'd1;
        end
    end

    assign total_vedadas = tot_q;
`endif

endmodule

// File: tb/tb_mef_vedacao.sv
module tb_mef_vedacao;

    logic       clk = 1'b0;
    logic       reset, start, pos_ve, reabastecer;
    logic       vedador, ve_done, alarme, ocupado;
    logic [3:0] rolhas;
`ifdef VEDACAO_CONTADOR_EN
    logic [15:0] total_vedadas;
`endif

    mef_vedacao dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pos_ve      (pos_ve),
        .reabastecer (reabastecer),
        .vedador     (vedador),
        .ve_done     (ve_done),
        .alarme      (alarme),
        .ocupado     (ocupado),
        .rolhas      (rolhas)
`ifdef VEDACAO_CONTADOR_EN
        ,
        .total_vedadas (total_vedadas)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       ved, vd, al, oc;
        logic [3:0] ro;
        bit         ct;
        logic [15:0] tot;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] rm;   // model of the cork count

    task automatic push(input int c, input logic ved, input logic vd, input logic al,
                        input logic oc, input logic [3:0] ro, input string nm);
        exp_t e;
        e.cyc = c; e.ved = ved; e.vd = vd; e.al = al; e.oc = oc; e.ro = ro;
        e.ct = 1'b0; e.tot = '0; e.nm = nm;
        q.push_back(e);
    endtask

`ifdef VEDACAO_CONTADOR_EN
    task automatic push_tot(input int c, input logic [15:0] t, input string nm);
        exp_t e;
        e.cyc = c; e.ved = 0; e.vd = 0; e.al = 0; e.oc = 0; e.ro = '0;
        e.ct = 1'b1; e.tot = t; e.nm = nm;
        q.push_back(e);
    endtask
`endif

    // Monitor: outputs are sampled on the falling edge and compared against
    // whatever the stimulus queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    failures++;
                    $display("FAIL %s: expectation for cycle %0d not checked, now %0d", e.nm, e.cyc, cyc);
                end else if (e.ct) begin
`ifdef VEDACAO_CONTADOR_EN
                    if (total_vedadas !== e.tot) begin
                        failures++;
                        $display("FAIL %s: total_vedadas got %h want %h", e.nm, total_vedadas, e.tot);
                    end
`endif
                end else if ({vedador, ve_done, alarme, ocupado, rolhas} !==
                             {e.ved, e.vd, e.al, e.oc, e.ro}) begin
                    failures++;
                    $display("FAIL %s @%0d: got ved=%b done=%b al=%b oc=%b rol=%0d want ved=%b done=%b al=%b oc=%b rol=%0d",
                             e.nm, cyc, vedador, ve_done, alarme, ocupado, rolhas,
                             e.ved, e.vd, e.al, e.oc, e.ro);
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin @(posedge clk); #2; end
    endtask

    // Full seal with pos_ve held: 4 cycles DS, 2 SB, 2 OK held, then pos_ve
    // drops and the block is idle one cycle later. rf refills in the same
    // cycle the ID->DS transition is taken.
    task automatic seal(input logic rf, input string nm);
        int n;
        logic [3:0] r1;
        logic al;
        n  = cyc;
        r1 = (rf ? 4'd15 : rm) - 4'd1;
        rm = r1;
        al = (r1 == 4'd0);
        pos_ve = 1'b1;
        reabastecer = rf;
        for (int k = 1; k <= 4; k++) push(n + k, 1, 0, al, 1, r1, {nm, " ds"});
        for (int k = 5; k <= 6; k++) push(n + k, 0, 0, al, 1, r1, {nm, " sb"});
        for (int k = 7; k <= 8; k++) push(n + k, 0, 1, al, 1, r1, {nm, " ok"});
        step(1);
        reabastecer = 1'b0;
        step(7);
        pos_ve = 1'b0;
        push(n + 9, 0, 0, al, 0, r1, {nm, " idle"});
        step(1);
    endtask

    task automatic abort_seal(input string nm);
        int n;
        n  = cyc;
        rm = rm - 4'd1;
        pos_ve = 1'b1;
        push(n + 1, 1, 0, rm == 0, 1, rm, {nm, " ds1"});
        push(n + 2, 1, 0, rm == 0, 1, rm, {nm, " ds2"});
        step(2);
        start = 1'b0;
        push(n + 3, 0, 0, rm == 0, 0, rm, {nm, " aborted"});
        push(n + 4, 0, 0, rm == 0, 0, rm, {nm, " held idle"});
        step(2);
        start  = 1'b1;
        pos_ve = 1'b0;
        step(1);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; pos_ve = 1'b0; reabastecer = 1'b0;
        rm = 4'd15;
        step(2);
        push(cyc, 0, 0, 0, 0, 15, "reset state");
        step(1);
        reset = 1'b0; start = 1'b1;
        step(1);

        // First seal, then drain the magazine to zero.
        seal(0, "seal1");
        for (int i = 0; i < 14; i++) seal(0, "drain");

        // Empty magazine: fault, then refill restarts the sequence.
        n = cyc;
        pos_ve = 1'b1;
        push(n + 1, 0, 0, 1, 1, 0, "fault1");
        push(n + 2, 0, 0, 1, 1, 0, "fault2");
        step(2);
        reabastecer = 1'b1;
        push(n + 3, 0, 0, 0, 0, 15, "fault refill");
        step(1);
        reabastecer = 1'b0;
        rm = 4'd15;
        seal(0, "after refill");

        // Bring stock to 3, then refill coincident with the consume.
        for (int i = 0; i < 11; i++) seal(0, "to3");
        seal(1, "refill+consume");

        abort_seal("abort");

        // Async reset in the middle of retraction.
        n = cyc;
        pos_ve = 1'b1;
        rm = rm - 4'd1;
        for (int k = 1; k <= 4; k++) push(n + k, 1, 0, 0, 1, rm, "pre-reset ds");
        push(n + 5, 0, 0, 0, 1, rm, "pre-reset sb");
        step(6);
        reset = 1'b1;
        push(cyc, 0, 0, 0, 0, 15, "async reset");
        rm = 4'd15;
        step(1);
        reset = 1'b0; pos_ve = 1'b0;
        step(1);

`ifdef VEDACAO_CONTADOR_EN
        push_tot(cyc, 16'd0, "tot reset");
        seal(0, "cnt a"); seal(0, "cnt b"); seal(0, "cnt c");
        abort_seal("cnt abort");
        push_tot(cyc, 16'd3, "tot 3+1");
        force dut.tot_q = 16'hFFFE;
        step(1);
        release dut.tot_q;
        step(1);
        push_tot(cyc, 16'hFFFE, "tot preload");
        seal(0, "sat a"); seal(0, "sat b");
        push_tot(cyc, 16'hFFFF, "tot saturate");
`endif

        step(3);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations never checked", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
